// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/execute sequencer owning PC, IR and the program-memory handshake
//
// Purpose:
//   Fetches one instruction at a time from program memory and holds it in the
//   instruction register for the decoder. For each ordinary instruction it
//   raises a one-cycle execute qualifier. The control opcodes JMP, JNC and HLT
//   are carried out here and are never passed to the datapath.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   Run      in   start/resume request, only looked at in IDLE and HALT
//   PM_Addr  out  program-memory address (always equal to PC)
//   PM_Req   out  fetch request, high for the whole FETCH state
//   PM_Ack   in   program memory has PM_Data valid this cycle
//   PM_Data  in   instruction word from program memory
//   Ins      out  instruction register
//   Exec_En  out  one-cycle execute qualifier for the decoder CE strobes
//   Carry    in   registered ALU carry flag, tested by JNC
//   Halted   out  high in IDLE and HALT
//   PC       out  program counter, for observation

module program_sequencer #(
    parameter int PC_WIDTH   = 8,
    parameter int INS_WIDTH  = 13,
    parameter int OPCODE_JMP = 29,
    parameter int OPCODE_JNC = 30,
    parameter int OPCODE_HLT = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Run,
    output logic [PC_WIDTH-1:0]  PM_Addr,
    output logic                 PM_Req,
    input  logic                 PM_Ack,
    input  logic [INS_WIDTH-1:0] PM_Data,
    output logic [INS_WIDTH-1:0] Ins,
    output logic                 Exec_En,
    input  logic                 Carry,
    output logic                 Halted,
    output logic [PC_WIDTH-1:0]  PC
);

    localparam int OP_WIDTH = 5;

    localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(OPCODE_JMP);
    localparam logic [OP_WIDTH-1:0] OP_JNC = OP_WIDTH'(OPCODE_JNC);
    localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(OPCODE_HLT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INS_WIDTH-1:0]   ins_q, ins_d;

    logic [OP_WIDTH-1:0]    opcode;
    logic [PC_WIDTH-1:0]    jump_target;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic                   is_ctrl;

    // The opcode sits in the top bits; the jump target is the low data field.
    assign opcode      = ins_q[INS_WIDTH-1 -: OP_WIDTH];
    assign jump_target = ins_q[PC_WIDTH-1:0];
    // Natural wrap at 2^PC_WIDTH, no flag on overflow.
    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign is_ctrl     = (opcode == OP_JMP) || (opcode == OP_JNC) || (opcode == OP_HLT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Address and request stay put until memory answers; no timeout.
                if (PM_Ack) begin
                    ins_d   = PM_Data;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_JMP: pc_d = jump_target;
                    // Carry is the flag left by the last completed ADD/SUB.
                    OP_JNC: pc_d = Carry ? pc_inc : jump_target;
                    // PC already advanced, so Run resumes after the HLT.
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs come only from registers, so reset drops them in the same cycle
    // and no input reaches an output combinationally.
    always_comb begin
        PM_Req  = (state_q == ST_FETCH);
        Exec_En = (state_q == ST_EXEC) && !is_ctrl;
        Halted  = (state_q == ST_IDLE) || (state_q == ST_HALT);
        PM_Addr = pc_q;
        PC      = pc_q;
        Ins     = ins_q;
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - instruction-level reference bench for program_sequencer

module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        Run;
    logic [7:0]  PM_Addr;
    logic        PM_Req;
    logic        PM_Ack;
    logic [12:0] PM_Data;
    logic [12:0] Ins;
    logic        Exec_En;
    logic        Carry;
    logic        Halted;
    logic [7:0]  PC;

    program_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .Run     (Run),
        .PM_Addr (PM_Addr),
        .PM_Req  (PM_Req),
        .PM_Ack  (PM_Ack),
        .PM_Data (PM_Data),
        .Ins     (Ins),
        .Exec_En (Exec_En),
        .Carry   (Carry),
        .Halted  (Halted),
        .PC      (PC)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] mem [256];
    logic [7:0]  mpc;
    logic [12:0] mins;
    bit          mhalted;
    int          exp_pulses = 0;

    int pulses = 0;
    int b2b = 0;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            pulses  <= pulses + int'(Exec_En);
            b2b     <= b2b + int'(Exec_En && prev_en);
            prev_en <= Exec_En;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_ctrl(input logic [12:0] w);
        return w[12:8] >= 5'd29;
    endfunction

    task automatic resume(input int idle_cycles);
        Run = 1'b0;
        for (int i = 0; i < idle_cycles; i++) begin
            PM_Ack  = 1'($urandom);
            PM_Data = 13'($urandom);
            step();
            check("idle_halted", Halted, 1);
            check("idle_req", PM_Req, 0);
            check("idle_ins", Ins, mins);
            check("idle_pc", PC, mpc);
        end
        Run     = 1'b1;
        PM_Ack  = 1'($urandom);
        PM_Data = 13'($urandom);
        step();
        Run = 1'b0;
        check("resume_req", PM_Req, 1);
        check("resume_addr", PM_Addr, mpc);
        check("resume_halted", Halted, 0);
        mhalted = 1'b0;
    endtask

    // csel: 0/1 force Carry during EXEC, 2 randomizes it.
    task automatic run_instr(input int delay, input int csel);
        logic [12:0] w;
        logic        c;
        logic [4:0]  op;
        check("fetch_req", PM_Req, 1);
        check("fetch_addr", PM_Addr, mpc);
        for (int i = 0; i < delay; i++) begin
            PM_Ack  = 1'b0;
            PM_Data = 13'($urandom);
            Run     = 1'($urandom);
            step();
            check("wait_req", PM_Req, 1);
            check("wait_addr", PM_Addr, mpc);
            check("wait_ins", Ins, mins);
            check("wait_exec", Exec_En, 0);
        end
        w       = mem[mpc];
        PM_Ack  = 1'b1;
        PM_Data = w;
        Run     = 1'($urandom);
        step();
        mins = w;
        c = (csel == 2) ? 1'($urandom) : 1'(csel);
        Carry   = c;
        PM_Ack  = 1'($urandom);
        PM_Data = 13'($urandom);
        Run     = 1'($urandom);
        check("exec_ins", Ins, w);
        check("exec_en", Exec_En, !is_ctrl(w));
        check("exec_req", PM_Req, 0);
        check("exec_halted", Halted, 0);
        if (!is_ctrl(w)) exp_pulses++;
        op = w[12:8];
        if (op == 5'd29 || (op == 5'd30 && !c)) mpc = w[7:0];
        else mpc = mpc + 8'd1;
        mhalted = (op == 5'd31);
        step();
        Run    = 1'b0;
        PM_Ack = 1'b0;
        check("next_pc", PC, mpc);
        check("next_ins", Ins, mins);
        check("next_halted", Halted, mhalted);
        check("next_req", PM_Req, !mhalted);
        check("next_exec", Exec_En, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, PM_Req, 0);
        check({tag, "_exec"}, Exec_En, 0);
        check({tag, "_pc"}, PC, 0);
        check({tag, "_ins"}, Ins, 0);
        check({tag, "_halted"}, Halted, 1);
    endtask

    initial begin
        int r;
        logic [4:0] op;
        rst = 1'b1; Run = 1'b0; PM_Ack = 1'b1; PM_Data = 13'h1FFF; Carry = 1'b0;
        step();
        step();
        check_reset_outputs("rst0");
        rst = 1'b0;
        PM_Ack = 1'b0;
        mpc = 8'd0; mins = 13'd0; mhalted = 1'b1;

        for (int a = 0; a < 256; a++) mem[a] = 13'($urandom_range(0, 28) << 8) | 13'($urandom_range(0, 255));
        mem[8'h00] = 13'h1800;
        mem[8'h01] = 13'h1D10;
        mem[8'h10] = 13'h1F00;
        mem[8'h11] = 13'h1E40;
        mem[8'h12] = 13'h1E40;
        mem[8'h40] = 13'h0555;
        mem[8'h41] = 13'h1DFF;
        mem[8'hFF] = 13'h0123;

        resume(1);
        run_instr(0, 2);
        run_instr(0, 2);
        run_instr(1, 2);
        check("hlt_halted", Halted, 1);
        check("hlt_pc", PC, 8'h11);
        resume(2);
        run_instr(0, 1);
        check("jnc_c1_pc", PC, 8'h12);
        run_instr(2, 0);
        check("jnc_c0_pc", PC, 8'h40);
        run_instr(3, 2);
        run_instr(0, 2);
        run_instr(0, 2);
        check("wrap_pc", PC, 8'h00);

        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 99);
            if (r < 10) op = 5'd29;
            else if (r < 20) op = 5'd30;
            else if (r < 24) op = 5'd31;
            else op = 5'($urandom_range(0, 28));
            mem[a] = {op, 8'($urandom)};
        end
        for (int n = 0; n < 400; n++) begin
            if (mhalted) resume($urandom_range(0, 3));
            run_instr($urandom_range(0, 3), 2);
        end

        if (mhalted) resume(0);
        PM_Ack = 1'b1; PM_Data = 13'h1234;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_fetch");
        step();
        check_reset_outputs("rst_fetch_ack");
        rst = 1'b0; PM_Ack = 1'b0;
        mpc = 8'd0; mins = 13'd0; mhalted = 1'b1;

        mem[8'h00] = 13'h0101;
        resume(1);
        PM_Ack = 1'b1; PM_Data = mem[8'h00];
        step();
        check("pre_rst_exec", Exec_En, 1);
        check("pre_rst_ins", Ins, 13'h0101);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_exec");
        step();
        rst = 1'b0; PM_Ack = 1'b0;
        step();
        check_reset_outputs("post_rst");

        step();
        check("exec_pulse_count", pulses, exp_pulses);
        check("exec_back_to_back", b2b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
